// File: rtl/trig_frame_scheduler_pkg.sv
// Shared constants and state encoding for the frame-aligned trigger scheduler.
package trig_sched_pkg;

   localparam logic [1:0] PH_FIRST    = 2'd0;
   localparam logic [1:0] PH_LAST     = 2'd3;
   localparam int         HOLDOFF_MAX = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      HOLD = 2'd2
   } sched_state_t;

endpackage

// File: rtl/trig_frame_scheduler_if.sv
// Request/trigger bundle between the requesters (master) and the scheduler (slave).
// With TRIG_SCHED_STATS_EN defined, the trigger/drop statistics counters are carried too.
interface trig_frame_scheduler_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic            en;
   logic [NREQ-1:0] req;
   logic            ovf_clr;
   logic [1:0]      phase;
   logic            trig_out;
   logic [IDW-1:0]  trig_id;
   logic            busy;
   logic            overflow;
`ifdef TRIG_SCHED_STATS_EN
   logic [15:0]     trig_count;
   logic [15:0]     drop_count;

   modport master (
      output en, req, ovf_clr,
      input  phase, trig_out, trig_id, busy, overflow, trig_count, drop_count
   );
   modport slave (
      input  en, req, ovf_clr,
      output phase, trig_out, trig_id, busy, overflow, trig_count, drop_count
   );
`else
   modport master (
      output en, req, ovf_clr,
      input  phase, trig_out, trig_id, busy, overflow
   );
   modport slave (
      input  en, req, ovf_clr,
      output phase, trig_out, trig_id, busy, overflow
   );
`endif
endinterface

// File: rtl/trig_frame_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  winner,
   output logic            valid
);

   logic [IDW-1:0] idx;

   always_comb begin
      winner = ptr;
      valid  = 1'b0;
      idx    = '0;
      // Farthest candidate first, so the nearest one after ptr is the last to overwrite.
      for (int k = NREQ; k >= 1; k--) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/trig_frame_scheduler.sv
// Frame-aligned round-robin trigger scheduler with post-trigger holdoff.
// Optional TRIG_SCHED_STATS_EN adds saturating trigger/drop counters.
//
// state | meaning
// IDLE  | no trigger in flight; arbitrate at every frame boundary
// FIRE  | trig_out high for the whole current frame
// HOLD  | forced idle frames; hold_cnt counts boundaries down to re-arbitration
module trig_frame_scheduler
   import trig_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int HOLDOFF = 2,
   parameter int IDW     = 2
) (
   input logic                   fastclk,
   input logic                   reset,
   trig_frame_scheduler_if.slave bus
);

   logic [1:0]      phase;
   sched_state_t    state;
   logic [NREQ-1:0] pending;
   logic [IDW-1:0]  rr_ptr;
   logic [3:0]      hold_cnt;
   logic            trig_out;
   logic [IDW-1:0]  trig_id;
   logic            overflow;

   logic            boundary;
   logic            arb_now;
   logic            grant;
   logic [IDW-1:0]  win_idx;
   logic            win_vld;
   logic [NREQ-1:0] grant_vec;
   logic [NREQ-1:0] drop_vec;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req    (pending),
      .ptr    (rr_ptr),
      .winner (win_idx),
      .valid  (win_vld)
   );

   assign boundary = (phase == PH_LAST);

   always_comb begin
      arb_now = 1'b0;
      if (boundary) begin
         case (state)
            IDLE:    arb_now = 1'b1;
            FIRE:    arb_now = (HOLDOFF == 0);
            HOLD:    arb_now = (hold_cnt <= 4'd1);
            default: arb_now = 1'b0;
         endcase
      end
   end

   assign grant     = arb_now && bus.en && win_vld;
   assign grant_vec = grant ? (NREQ'(1) << win_idx) : '0;
   // A repeat request is only lost when the same cycle does not also consume it.
   assign drop_vec  = bus.req & pending & ~grant_vec;

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         phase    <= PH_FIRST;
         state    <= IDLE;
         pending  <= '0;
         rr_ptr   <= IDW'(NREQ - 1);
         hold_cnt <= '0;
         trig_out <= 1'b0;
         trig_id  <= '0;
         overflow <= 1'b0;
      end else begin
         phase   <= phase + 2'd1;
         pending <= (pending & ~grant_vec) | bus.req;
         if (|drop_vec)
            overflow <= 1'b1;
         else if (bus.ovf_clr)
            overflow <= 1'b0;
         if (boundary && state == HOLD)
            hold_cnt <= hold_cnt - 4'd1;
         if (grant) begin
            state    <= FIRE;
            trig_out <= 1'b1;
            trig_id  <= win_idx;
            rr_ptr   <= win_idx;
         end else if (arb_now) begin
            state    <= IDLE;
            trig_out <= 1'b0;
         end else if (boundary && state == FIRE) begin
            state    <= HOLD;
            trig_out <= 1'b0;
            hold_cnt <= 4'(HOLDOFF);
         end
      end
   end

   assign bus.phase    = phase;
   assign bus.trig_out = trig_out;
   assign bus.trig_id  = trig_id;
   assign bus.busy     = (state != IDLE) || (|pending);
   assign bus.overflow = overflow;

`ifdef TRIG_SCHED_STATS_EN
   logic [15:0] trig_count;
   logic [15:0] drop_count;

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         trig_count <= '0;
         drop_count <= '0;
      end else begin
         if (grant && trig_count != 16'hFFFF)
            trig_count <= trig_count + 16'd1;
         if ((|drop_vec) && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
      end
   end

   assign bus.trig_count = trig_count;
   assign bus.drop_count = drop_count;
`endif

endmodule

// File: tb/tb_trig_frame_scheduler.sv
// Bench for trig_frame_scheduler: HOLDOFF=2 and HOLDOFF=0 instances share stimulus.
`timescale 1ns/1ps
module tb_trig_frame_scheduler;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic            fastclk = 1'b0;
   logic            reset   = 1'b1;
   logic            en      = 1'b1;
   logic [NREQ-1:0] req     = '0;
   logic            ovf_clr = 1'b0;

   always #5 fastclk = ~fastclk;

   trig_frame_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus_a ();
   trig_frame_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus_b ();

   assign bus_a.en      = en;
   assign bus_a.req     = req;
   assign bus_a.ovf_clr = ovf_clr;
   assign bus_b.en      = en;
   assign bus_b.req     = req;
   assign bus_b.ovf_clr = ovf_clr;

   trig_frame_scheduler #(.NREQ(NREQ), .HOLDOFF(2), .IDW(IDW)) dut_a (
      .fastclk (fastclk),
      .reset   (reset),
      .bus     (bus_a)
   );

   trig_frame_scheduler #(.NREQ(NREQ), .HOLDOFF(0), .IDW(IDW)) dut_b (
      .fastclk (fastclk),
      .reset   (reset),
      .bus     (bus_b)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a trigger blocks further grants for (holdoff+1) boundaries.
   typedef struct {
      int              cyc;
      int              blocked;
      int              ptr;
      int              id;
      bit              fire;
      bit [NREQ-1:0]   pend;
      bit              ovf;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.cyc = 0; m.blocked = 0; m.ptr = NREQ - 1; m.id = 0;
      m.fire = 1'b0; m.pend = '0; m.ovf = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int holdoff, bit e, bit [NREQ-1:0] r, bit clr);
      mdl_t n = m;
      int   win = -1;
      bit   drop = 1'b0;
      if (m.cyc % 4 == 3) begin
         n.fire = 1'b0;
         if (n.blocked > 0) n.blocked--;
         if (n.blocked == 0 && e) begin
            for (int k = 1; k <= NREQ; k++)
               if (win < 0 && m.pend[(m.ptr + k) % NREQ]) win = (m.ptr + k) % NREQ;
            if (win >= 0) begin
               n.fire = 1'b1; n.id = win; n.ptr = win; n.blocked = holdoff + 1;
            end
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (r[i]) begin
            if (m.pend[i] && i != win) drop = 1'b1;
            n.pend[i] = 1'b1;
         end else if (i == win) begin
            n.pend[i] = 1'b0;
         end
      end
      if (drop) n.ovf = 1'b1;
      else if (clr) n.ovf = 1'b0;
      n.cyc = m.cyc + 1;
      return n;
   endfunction

   function automatic logic [6:0] mvec(mdl_t m);
      return {2'(m.cyc % 4), m.fire, IDW'(m.id), (m.blocked > 0) || (|m.pend), m.ovf};
   endfunction

   function automatic logic [6:0] avec_a();
      return {bus_a.phase, bus_a.trig_out, bus_a.trig_id, bus_a.busy, bus_a.overflow};
   endfunction

   function automatic logic [6:0] avec_b();
      return {bus_b.phase, bus_b.trig_out, bus_b.trig_id, bus_b.busy, bus_b.overflow};
   endfunction

   task automatic tick();
      @(posedge fastclk);
      ma = mdl_step(ma, 2, en, req, ovf_clr);
      mb = mdl_step(mb, 0, en, req, ovf_clr);
      @(negedge fastclk);
      check($sformatf("model_a cyc%0d", ma.cyc), 32'(avec_a()), 32'(mvec(ma)));
      check($sformatf("model_b cyc%0d", mb.cyc), 32'(avec_b()), 32'(mvec(mb)));
   endtask

   task automatic hold_reset();
      reset = 1'b1; req = '0; ovf_clr = 1'b0; en = 1'b1;
      ma = mdl_reset(); mb = mdl_reset();
      @(negedge fastclk);
      @(negedge fastclk);
      reset = 1'b0;
   endtask

   typedef struct packed {
      logic [NREQ-1:0] req;
      logic            en;
      logic            clr;
      logic [1:0]      ph;
      logic            trig;
      logic [IDW-1:0]  id;
      logic            busy;
      logic            ovf;
   } vec_t;

   function automatic vec_t mk(int r, int e, int c, int ph, int t, int id, int b, int o);
      vec_t v;
      v.req = NREQ'(r); v.en = 1'(e); v.clr = 1'(c); v.ph = 2'(ph);
      v.trig = 1'(t); v.id = IDW'(id); v.busy = 1'(b); v.ovf = 1'(o);
      return v;
   endfunction

   initial begin
      vec_t tbl [22];
      int   seen, n, exp_wait, t, run, max_run;
      bit   prev;
      int   rise_t [$];
      int   rise_id [$];
      int   ids_b [$];

      // Single req[2], full frame + 8-cycle holdoff, then double req[1] overflow and clear.
      tbl[0] = mk(4'b0000, 1, 0, 1, 0, 0, 0, 0);
      tbl[1] = mk(4'b0100, 1, 0, 2, 0, 0, 1, 0);
      tbl[2] = mk(4'b0000, 1, 0, 3, 0, 0, 1, 0);
      for (int i = 3; i <= 6; i++)  tbl[i] = mk(0, 1, 0, (i - 3) % 4, 1, 2, 1, 0);
      for (int i = 7; i <= 14; i++) tbl[i] = mk(0, 1, 0, (i - 7) % 4, 0, 2, 1, 0);
      tbl[15] = mk(4'b0000, 1, 0, 0, 0, 2, 0, 0);
      tbl[16] = mk(4'b0010, 1, 0, 1, 0, 2, 1, 0);
      tbl[17] = mk(4'b0010, 1, 0, 2, 0, 2, 1, 1);
      tbl[18] = mk(4'b0000, 1, 0, 3, 0, 2, 1, 1);
      tbl[19] = mk(4'b0000, 1, 0, 0, 1, 1, 1, 1);
      tbl[20] = mk(4'b0000, 1, 1, 1, 1, 1, 1, 0);
      tbl[21] = mk(4'b0000, 1, 0, 2, 1, 1, 1, 0);

      hold_reset();
      check("reset_a", 32'(avec_a()), 32'd0);
      check("reset_b", 32'(avec_b()), 32'd0);

      for (int i = 0; i < 22; i++) begin
         req = tbl[i].req; en = tbl[i].en; ovf_clr = tbl[i].clr;
         tick();
         check($sformatf("vec%0d", i), 32'(avec_a()),
               32'({tbl[i].ph, tbl[i].trig, tbl[i].id, tbl[i].busy, tbl[i].ovf}));
      end
      req = '0; ovf_clr = 1'b0; en = 1'b1;
      repeat (16) tick();

      // Grants blocked while en is low; release lands on the next frame start.
      en = 1'b0; req = 4'b1000;
      tick();
      req = '0;
      seen = 0;
      repeat (20) begin
         tick();
         if (bus_a.trig_out || bus_b.trig_out) seen++;
      end
      check("en_low_no_trig", 32'(seen), 32'd0);
      en = 1'b1;
      exp_wait = 4 - (ma.cyc % 4);
      n = 0;
      while (n < 8 && !bus_a.trig_out) begin
         tick();
         n++;
      end
      check("en_release_latency", 32'(n), 32'(exp_wait));
      check("en_release_id", 32'(bus_a.trig_id), 32'd3);
      check("en_release_phase", 32'(bus_a.phase), 32'd0);

      // Asynchronous reset in phase 2 of a trigger frame.
      tick();
      tick();
      check("fire_before_reset", 32'(bus_a.trig_out), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("async_drop_a", 32'(bus_a.trig_out), 32'd0);
      check("async_drop_b", 32'(bus_b.trig_out), 32'd0);
      hold_reset();
      check("post_reset_a", 32'(avec_a()), 32'd0);

      // All four sources at once: rotation 0..3, one rise every 12 cycles.
      req = 4'b1111;
      tick();
      req = '0;
      prev = 1'b0;
      for (t = 1; t <= 60; t++) begin
         tick();
         if (bus_a.trig_out && !prev) begin
            rise_t.push_back(t);
            rise_id.push_back(int'(bus_a.trig_id));
         end
         prev = bus_a.trig_out;
      end
      check("rr_rise_count", 32'(rise_t.size()), 32'd4);
      for (int i = 0; i < rise_t.size() && i < 4; i++) begin
         check($sformatf("rr_id%0d", i), 32'(rise_id[i]), 32'(i));
         if (i > 0) check($sformatf("rr_gap%0d", i), 32'(rise_t[i] - rise_t[i-1]), 32'd12);
      end
      check("rr_no_overflow", 32'(bus_a.overflow), 32'd0);

      // Zero holdoff: two sources give eight continuous high cycles.
      req = 4'b0011;
      tick();
      req = '0;
      run = 0; max_run = 0;
      repeat (24) begin
         tick();
         if (bus_b.trig_out) begin
            run++;
            if (run > max_run) max_run = run;
            if (bus_b.phase == 2'd0) ids_b.push_back(int'(bus_b.trig_id));
         end else begin
            run = 0;
         end
      end
      check("b2b_run", 32'(max_run), 32'd8);
      check("b2b_frames", 32'(ids_b.size()), 32'd2);
      if (ids_b.size() == 2) begin
         check("b2b_id0", 32'(ids_b[0]), 32'd0);
         check("b2b_id1", 32'(ids_b[1]), 32'd1);
      end

      // Random traffic against the model.
      repeat (3000) begin
         for (int b = 0; b < NREQ; b++) req[b] = ($urandom_range(7) == 0);
         en      = ($urandom_range(7) != 0);
         ovf_clr = ($urandom_range(15) == 0);
         tick();
      end
      req = '0; ovf_clr = 1'b0; en = 1'b1;
      repeat (8) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/trig_frame_scheduler.md
Name: trig_frame_scheduler

Overview:
Arbitrates trigger requests from several sources onto the single trigger-encoding datapath, which uses a 4-phase frame of fastclk. It runs a free-running 2-bit frame-phase counter and buffers one pending request per source. At each frame boundary it grants one source in round-robin order and drives trig_out high for exactly one full frame. A programmable holdoff of idle frames follows each trigger, so the downstream duty-cycle encoder always sees frame-aligned, spaced triggers.

Parameters:
NREQ, 4, number of requesters; legal range 2..8.
HOLDOFF, 2, forced idle frames after each trigger frame; legal range 0..15.
IDW, 2, width of trig_id; must equal clog2(NREQ).

Ports:
fastclk  in  1  encoder fast clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high.
en  in  1  grant enable; when low, no new grants are issued.
req  in  NREQ  per-source request pulses, synchronous to fastclk; each high cycle is one request.
ovf_clr  in  1  clears the sticky overflow flag.
phase  out  2  frame-phase counter value (0..3).
trig_out  out  1  trigger to the encoder; high for phases 0..3 of a granted frame.
trig_id  out  IDW  index of the granted source; valid while trig_out is high.
busy  out  1  high when state is not IDLE or any request is pending.
overflow  out  1  sticky flag: a request arrived while that source was already pending.

Behaviour:
- Reset values: phase=0, state=IDLE, pending=0, rr_ptr=NREQ-1 (so source 0 wins first), trig_out=0, trig_id=0, overflow=0, holdoff count=0.
- phase increments every cycle and wraps 3->0. Frame boundary = the cycle where phase==3. All state transitions happen on that edge.
- pending[i]:
  - Set on req[i]=1.
  - Cleared when source i is granted.
  - If set and clear occur in the same cycle, set wins: pending stays 1 and no overflow is flagged.
  - If req[i]=1 while pending[i]=1 and source i is not being granted that cycle, the request is dropped and overflow is set.
- Arbitration uses registered pending only. A req that arrives in the phase==3 cycle is considered at the next boundary.
- Round-robin: search upward from rr_ptr+1, wrapping modulo NREQ. The first pending source wins, and rr_ptr takes the winner's index.
- State machine:
  - IDLE -> FIRE at a boundary when en=1 and any pending bit is set. Winner latched into trig_id.
  - FIRE -> HOLD at the next boundary, loading the holdoff count with HOLDOFF. If HOLDOFF=0, FIRE goes directly to a re-arbitration with the same rules as IDLE, so back-to-back frames are possible.
  - HOLD: the count decrements at each boundary. When it reaches 0 at a boundary, the block arbitrates as in IDLE; if nothing is granted, it goes to IDLE.
- trig_out is a registered output equal to (state==FIRE). It rises exactly at phase 0 and stays high for 4 cycles. Latency from a pending bit visible at phase 3 to trig_out high is 1 cycle.
- trig_id holds its last value outside FIRE.
- en low: blocks new grants only. A FIRE in progress completes, HOLD keeps counting, and requests still accumulate.
- ovf_clr clears overflow. If ovf_clr and a new overflow occur in the same cycle, the set wins.
- Reset mid-FIRE: trig_out drops asynchronously and the block returns to reset values.

Optional Feature:
TRIG_SCHED_STATS_EN.
- Defined: adds outputs trig_count[15:0] and drop_count[15:0].
  - trig_count increments on each FIRE entry; drop_count increments on each dropped request.
  - Both counters saturate at 16'hFFFF and reset to 0.
  - Dropped requests from several sources in one cycle count as one.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package trig_sched_pkg:
  - frame-phase constants PH_FIRST=2'd0 and PH_LAST=2'd3;
  - state encoding typedef (IDLE, FIRE, HOLD);
  - HOLDOFF maximum constant.
- One sub-module: rr_arbiter (inputs NREQ-bit request vector and pointer; outputs winner index and valid). It is purely combinational and reusable.

Test Plan:
- Single req[2] pulse at phase 1 -> trig_out high for the 4 cycles of the next frame (phases 0..3), trig_id=2, then HOLD for 8 cycles, then IDLE with busy=0.
- req=4'b1111 in one cycle with HOLDOFF=2 -> grants to sources 0,1,2,3, each trig_out rise 12 cycles apart, overflow=0.
- req[1] pulsed twice while pending -> overflow=1 and only one trigger for source 1; ovf_clr pulse -> overflow=0.
- en=0 with req[3] pending for 20 cycles -> no trig_out; en=1 -> trig_out rises at the first phase 0 after the next phase-3 boundary.
- HOLDOFF=0, req[0] and req[1] pending -> two consecutive 4-cycle trig_out frames (trig_id 0 then 1), 8 cycles high continuously.
- Reset asserted at phase 2 of FIRE -> trig_out=0 immediately; after release, phase=0, pending=0, and the first grant goes to source 0.
